// File: rtl/lc4_div_sequencer.sv
// Shared iterative radix-2 restoring divider for pipes A and B.
// Round-robin arbitration, STEPS iterations per cycle, valid/ready response, flush.
module lc4_div_sequencer #(
  parameter int STEPS = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             a_req_valid,
  output logic             a_req_ready,
  input  logic [15:0]      a_dividend,
  input  logic [15:0]      a_divisor,
  input  logic [TAG_W-1:0] a_tag,
  input  logic             b_req_valid,
  output logic             b_req_ready,
  input  logic [15:0]      b_dividend,
  input  logic [15:0]      b_divisor,
  input  logic [TAG_W-1:0] b_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [15:0]      resp_quotient,
  output logic [15:0]      resp_remainder,
  output logic             resp_src,
  output logic [TAG_W-1:0] resp_tag
);

  localparam int         N    = 16 / STEPS;
  localparam logic [3:0] LAST = 4'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [15:0]      dvd_q, dvd_d;
  logic [15:0]      dvs_q, dvs_d;
  logic [15:0]      quo_q, quo_d;
  logic [15:0]      rem_q, rem_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             src_q, src_d;
  logic             last_grant_q, last_grant_d;  // 1 = B was granted last
  logic [15:0]      resp_quo_q, resp_quo_d;
  logic [15:0]      resp_rem_q, resp_rem_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_src_q, resp_src_d;

  logic             grant_a, grant_b, accept;
  logic [15:0]      step_dvd, step_quo, step_rem, trial;

  // Round-robin: on contention the port that did not win last time goes first.
  always_comb begin
    grant_a = a_req_valid & (~b_req_valid | last_grant_q);
    grant_b = b_req_valid & (~a_req_valid | ~last_grant_q);
    accept  = (state_q == IDLE) & ~flush & ~rst & (grant_a | grant_b);
  end

  // STEPS chained restoring-division iterations, 16-bit remainder throughout.
  always_comb begin
    step_dvd = dvd_q;
    step_quo = quo_q;
    step_rem = rem_q;
    trial    = '0;
    for (int i = 0; i < STEPS; i++) begin
      trial = {step_rem[14:0], step_dvd[15]};
      if (trial >= dvs_q) begin
        step_rem = trial - dvs_q;
        step_quo = {step_quo[14:0], 1'b1};
      end else begin
        step_rem = trial;
        step_quo = {step_quo[14:0], 1'b0};
      end
      step_dvd = step_dvd << 1;
    end
  end

  // NOTE: every register below, datapath included, is cleared by the synchronous
  // reset and updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      tag_q        <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      resp_quo_q   <= '0;
      resp_rem_q   <= '0;
      resp_tag_q   <= '0;
      resp_src_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      tag_q        <= tag_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      resp_quo_q   <= resp_quo_d;
      resp_rem_q   <= resp_rem_d;
      resp_tag_q   <= resp_tag_d;
      resp_src_q   <= resp_src_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    tag_d        = tag_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    resp_quo_d   = resp_quo_q;
    resp_rem_d   = resp_rem_q;
    resp_tag_d   = resp_tag_q;
    resp_src_d   = resp_src_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = BUSY;
          count_d      = '0;
          dvd_d        = grant_a ? a_dividend : b_dividend;
          dvs_d        = grant_a ? a_divisor  : b_divisor;
          tag_d        = grant_a ? a_tag      : b_tag;
          src_d        = grant_b;
          last_grant_d = grant_b;
          quo_d        = '0;
          rem_d        = '0;
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          dvd_d   = step_dvd;
          quo_d   = step_quo;
          rem_d   = step_rem;
          count_d = count_q + 4'd1;
          if (count_q == LAST) begin
            state_d = DONE;
            // A zero divisor runs full length but reports 0/0.
            resp_quo_d = (dvs_q == '0) ? '0 : step_quo;
            resp_rem_d = (dvs_q == '0) ? '0 : step_rem;
            resp_tag_d = tag_q;
            resp_src_d = src_q;
          end
        end
      end
      DONE: begin
        if (flush || resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_req_ready    = accept & grant_a;
    b_req_ready    = accept & grant_b;
    resp_valid     = (state_q == DONE);
    resp_quotient  = resp_quo_q;
    resp_remainder = resp_rem_q;
    resp_src       = resp_src_q;
    resp_tag       = resp_tag_q;
  end

endmodule

// File: tb/tb_lc4_div_sequencer.sv
// Directed bench for lc4_div_sequencer: STEPS=1 instance drives the main scenarios,
// STEPS=2 and STEPS=4 instances join the boundary-value latency cases.
module tb_lc4_div_sequencer;

  logic        clk = 1'b0;
  logic        rst, flush, resp_ready, bnd_en;
  logic        a_valid, b_valid;
  logic [15:0] a_dvd, a_dvs, b_dvd, b_dvs;
  logic [3:0]  a_tag, b_tag;
  logic        a_valid_x, b_valid_x;

  logic        a_rdy1, b_rdy1, rv1, src1;
  logic [15:0] q1, r1;
  logic [3:0]  tag1;
  logic        a_rdy2, b_rdy2, rv2, src2;
  logic [15:0] q2, r2;
  logic [3:0]  tag2;
  logic        a_rdy4, b_rdy4, rv4, src4;
  logic [15:0] q4, r4;
  logic [3:0]  tag4;

  int tests = 0;
  int fails = 0;

  assign a_valid_x = a_valid & bnd_en;
  assign b_valid_x = b_valid & bnd_en;

  always #5 clk = ~clk;

  lc4_div_sequencer #(.STEPS(1), .TAG_W(4)) u1 (
    .clk(clk), .rst(rst), .flush(flush),
    .a_req_valid(a_valid), .a_req_ready(a_rdy1), .a_dividend(a_dvd), .a_divisor(a_dvs), .a_tag(a_tag),
    .b_req_valid(b_valid), .b_req_ready(b_rdy1), .b_dividend(b_dvd), .b_divisor(b_dvs), .b_tag(b_tag),
    .resp_valid(rv1), .resp_ready(resp_ready), .resp_quotient(q1), .resp_remainder(r1),
    .resp_src(src1), .resp_tag(tag1));

  lc4_div_sequencer #(.STEPS(2), .TAG_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush),
    .a_req_valid(a_valid_x), .a_req_ready(a_rdy2), .a_dividend(a_dvd), .a_divisor(a_dvs), .a_tag(a_tag),
    .b_req_valid(b_valid_x), .b_req_ready(b_rdy2), .b_dividend(b_dvd), .b_divisor(b_dvs), .b_tag(b_tag),
    .resp_valid(rv2), .resp_ready(1'b1), .resp_quotient(q2), .resp_remainder(r2),
    .resp_src(src2), .resp_tag(tag2));

  lc4_div_sequencer #(.STEPS(4), .TAG_W(4)) u4 (
    .clk(clk), .rst(rst), .flush(flush),
    .a_req_valid(a_valid_x), .a_req_ready(a_rdy4), .a_dividend(a_dvd), .a_divisor(a_dvs), .a_tag(a_tag),
    .b_req_valid(b_valid_x), .b_req_ready(b_rdy4), .b_dividend(b_dvd), .b_divisor(b_dvs), .b_tag(b_tag),
    .resp_valid(rv4), .resp_ready(1'b1), .resp_quotient(q4), .resp_remainder(r4),
    .resp_src(src4), .resp_tag(tag4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the accept edge until resp_valid rises on the STEPS=1 unit; -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (rv1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    tick(); tick();
    tests++;
    if (a_rdy1 !== 1'b0 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL reset_ready: got a=%b b=%b expected 0 0", a_rdy1, b_rdy1);
    end
    tests++;
    if (rv1 !== 1'b0) begin
      fails++; $display("FAIL reset_valid: got %b expected 0", rv1);
    end
    tests++;
    if (q1 !== 16'h0 || r1 !== 16'h0 || tag1 !== 4'h0 || src1 !== 1'b0) begin
      fails++; $display("FAIL reset_resp: got q=%h r=%h tag=%h src=%b expected all 0", q1, r1, tag1, src1);
    end
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    resp_ready = 1'b1;
    a_dvd = 16'd100; a_dvs = 16'd7; a_tag = 4'd3; a_valid = 1'b1;
    #1;
    tests++;
    if (a_rdy1 !== 1'b1 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL basic_ready: got a=%b b=%b expected 1 0", a_rdy1, b_rdy1);
    end
    tick();
    tests++;
    if (a_rdy1 !== 1'b0) begin
      fails++; $display("FAIL basic_ready_once: got %b expected 0", a_rdy1);
    end
    a_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (lat != 16) begin
      fails++; $display("FAIL basic_latency: got %0d expected 16", lat);
    end
    tests++;
    if (q1 !== 16'd14 || r1 !== 16'd2 || src1 !== 1'b0 || tag1 !== 4'd3) begin
      fails++; $display("FAIL basic_result: got q=%0d r=%0d src=%b tag=%0d expected 14 2 0 3", q1, r1, src1, tag1);
    end
    tick();
    tests++;
    if (rv1 !== 1'b0) begin
      fails++; $display("FAIL basic_idle: got valid=%b expected 0", rv1);
    end
  endtask

  task automatic test_arbitration();
    int lat;
    rst = 1'b1; tick(); rst = 1'b0;
    resp_ready = 1'b1;
    a_dvd = 16'd20; a_dvs = 16'd3; a_tag = 4'd1; a_valid = 1'b1;
    b_dvd = 16'd9;  b_dvs = 16'd4; b_tag = 4'd2; b_valid = 1'b1;
    #1;
    tests++;
    if (a_rdy1 !== 1'b1 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL arb_first_a: got a=%b b=%b expected 1 0", a_rdy1, b_rdy1);
    end
    tick(); a_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (lat != 16 || q1 !== 16'd6 || r1 !== 16'd2 || src1 !== 1'b0 || tag1 !== 4'd1) begin
      fails++; $display("FAIL arb_a_result: got lat=%0d q=%0d r=%0d src=%b tag=%0d expected 16 6 2 0 1", lat, q1, r1, src1, tag1);
    end
    tick();
    tests++;
    if (b_rdy1 !== 1'b1) begin
      fails++; $display("FAIL arb_b_next: got %b expected 1", b_rdy1);
    end
    tick(); b_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (lat != 16 || q1 !== 16'd2 || r1 !== 16'd1 || src1 !== 1'b1 || tag1 !== 4'd2) begin
      fails++; $display("FAIL arb_b_result: got lat=%0d q=%0d r=%0d src=%b tag=%0d expected 16 2 1 1 2", lat, q1, r1, src1, tag1);
    end
    tick();
    // Lone A request leaves last_grant = A.
    a_dvd = 16'd8; a_dvs = 16'd2; a_tag = 4'd6; a_valid = 1'b1;
    tick(); a_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (q1 !== 16'd4 || r1 !== 16'd0 || src1 !== 1'b0) begin
      fails++; $display("FAIL arb_single_a: got q=%0d r=%0d src=%b expected 4 0 0", q1, r1, src1);
    end
    tick();
    a_dvd = 16'd30; a_dvs = 16'd4; a_tag = 4'd7; a_valid = 1'b1;
    b_dvd = 16'd50; b_dvs = 16'd8; b_tag = 4'd8; b_valid = 1'b1;
    #1;
    tests++;
    if (a_rdy1 !== 1'b0 || b_rdy1 !== 1'b1) begin
      fails++; $display("FAIL arb_third_b: got a=%b b=%b expected 0 1", a_rdy1, b_rdy1);
    end
    tick(); b_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (q1 !== 16'd6 || r1 !== 16'd2 || src1 !== 1'b1 || tag1 !== 4'd8) begin
      fails++; $display("FAIL arb_third_b_result: got q=%0d r=%0d src=%b tag=%0d expected 6 2 1 8", q1, r1, src1, tag1);
    end
    tick();
    tests++;
    if (a_rdy1 !== 1'b1) begin
      fails++; $display("FAIL arb_third_a_next: got %b expected 1", a_rdy1);
    end
    tick(); a_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (q1 !== 16'd7 || r1 !== 16'd2 || src1 !== 1'b0 || tag1 !== 4'd7) begin
      fails++; $display("FAIL arb_third_a_result: got q=%0d r=%0d src=%b tag=%0d expected 7 2 0 7", q1, r1, src1, tag1);
    end
    tick();
  endtask

  task automatic test_boundary();
    logic [15:0] dvd_v [4] = '{16'hFFFF, 16'hFFFF, 16'd5, 16'd3};
    logic [15:0] dvs_v [4] = '{16'd1,    16'hFFFF, 16'd0, 16'd10};
    logic [15:0] q_v   [4] = '{16'hFFFF, 16'd1,    16'd0, 16'd0};
    logic [15:0] r_v   [4] = '{16'd0,    16'd0,    16'd0, 16'd3};
    bnd_en = 1'b1; resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      int lat1, lat2, lat4;
      logic [15:0] cq1, cr1, cq2, cr2, cq4, cr4;
      lat1 = -1; lat2 = -1; lat4 = -1;
      cq1 = 'x; cr1 = 'x; cq2 = 'x; cr2 = 'x; cq4 = 'x; cr4 = 'x;
      a_dvd = dvd_v[c]; a_dvs = dvs_v[c]; a_tag = 4'(c); a_valid = 1'b1;
      tick(); a_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        if (rv1 && lat1 < 0) begin lat1 = k; cq1 = q1; cr1 = r1; end
        if (rv2 && lat2 < 0) begin lat2 = k; cq2 = q2; cr2 = r2; end
        if (rv4 && lat4 < 0) begin lat4 = k; cq4 = q4; cr4 = r4; end
      end
      tests++;
      if (lat1 != 16 || cq1 !== q_v[c] || cr1 !== r_v[c]) begin
        fails++; $display("FAIL bnd%0d_steps1: got lat=%0d q=%h r=%h expected 16 %h %h", c, lat1, cq1, cr1, q_v[c], r_v[c]);
      end
      tests++;
      if (lat2 != 8 || cq2 !== q_v[c] || cr2 !== r_v[c]) begin
        fails++; $display("FAIL bnd%0d_steps2: got lat=%0d q=%h r=%h expected 8 %h %h", c, lat2, cq2, cr2, q_v[c], r_v[c]);
      end
      tests++;
      if (lat4 != 4 || cq4 !== q_v[c] || cr4 !== r_v[c]) begin
        fails++; $display("FAIL bnd%0d_steps4: got lat=%0d q=%h r=%h expected 4 %h %h", c, lat4, cq4, cr4, q_v[c], r_v[c]);
      end
    end
    bnd_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    resp_ready = 1'b0;
    a_dvd = 16'd50; a_dvs = 16'd5; a_tag = 4'd9; a_valid = 1'b1;
    tick(); a_valid = 1'b0;
    b_dvd = 16'd17; b_dvs = 16'd5; b_tag = 4'd10; b_valid = 1'b1;
    wait_resp(lat);
    tests++;
    if (lat != 16 || q1 !== 16'd10 || r1 !== 16'd0) begin
      fails++; $display("FAIL bp_result: got lat=%0d q=%0d r=%0d expected 16 10 0", lat, q1, r1);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if (rv1 !== 1'b1 || q1 !== 16'd10 || r1 !== 16'd0 || tag1 !== 4'd9 || src1 !== 1'b0 || b_rdy1 !== 1'b0) begin
        fails++; $display("FAIL bp_hold%0d: got v=%b q=%0d r=%0d tag=%0d src=%b brdy=%b expected 1 10 0 9 0 0", k, rv1, q1, r1, tag1, src1, b_rdy1);
      end
    end
    resp_ready = 1'b1;
    #1;
    tests++;
    if (b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL bp_no_accept_in_done: got %b expected 0", b_rdy1);
    end
    tick();
    tests++;
    if (rv1 !== 1'b0 || b_rdy1 !== 1'b1) begin
      fails++; $display("FAIL bp_after_handshake: got v=%b brdy=%b expected 0 1", rv1, b_rdy1);
    end
    tick(); b_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (lat != 16 || q1 !== 16'd3 || r1 !== 16'd2 || src1 !== 1'b1 || tag1 !== 4'd10) begin
      fails++; $display("FAIL bp_b_result: got lat=%0d q=%0d r=%0d src=%b tag=%0d expected 16 3 2 1 10", lat, q1, r1, src1, tag1);
    end
    tick();
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    resp_ready = 1'b1;
    a_dvd = 16'd1000; a_dvs = 16'd10; a_tag = 4'd11; a_valid = 1'b1;
    tick(); a_valid = 1'b0;
    b_dvd = 16'd40; b_dvs = 16'd6; b_tag = 4'd12; b_valid = 1'b1;
    repeat (7) tick();
    flush = 1'b1;
    #1;
    tests++;
    if (b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL flush_busy_ready: got %b expected 0", b_rdy1);
    end
    tick();
    tests++;
    if (rv1 !== 1'b0 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL flush_idle_blocked: got v=%b brdy=%b expected 0 0", rv1, b_rdy1);
    end
    flush = 1'b0;
    #1;
    tests++;
    if (b_rdy1 !== 1'b1) begin
      fails++; $display("FAIL flush_b_accept: got %b expected 1", b_rdy1);
    end
    tick(); b_valid = 1'b0; resp_ready = 1'b0;
    wait_resp(lat);
    tests++;
    if (lat != 16 || q1 !== 16'd6 || r1 !== 16'd4 || src1 !== 1'b1 || tag1 !== 4'd12) begin
      fails++; $display("FAIL flush_b_result: got lat=%0d q=%0d r=%0d src=%b tag=%0d expected 16 6 4 1 12", lat, q1, r1, src1, tag1);
    end
    tick();
    flush = 1'b1; resp_ready = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if (rv1 !== 1'b0) begin
      fails++; $display("FAIL flush_done_drop: got %b expected 0", rv1);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (rv1) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL flush_no_redeliver: got %b expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    resp_ready = 1'b1;
    b_dvd = 16'd77; b_dvs = 16'd7; b_tag = 4'd13; b_valid = 1'b1;
    tick(); b_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    a_dvd = 16'd21; a_dvs = 16'd4; a_tag = 4'd14; a_valid = 1'b1;
    b_dvd = 16'd33; b_dvs = 16'd5; b_tag = 4'd15; b_valid = 1'b1;
    #1;
    tests++;
    if (a_rdy1 !== 1'b0 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL rstmid_ready_gate: got a=%b b=%b expected 0 0", a_rdy1, b_rdy1);
    end
    tick();
    tests++;
    if (rv1 !== 1'b0 || q1 !== 16'h0 || r1 !== 16'h0 || tag1 !== 4'h0 || src1 !== 1'b0 || a_rdy1 !== 1'b0 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL rstmid_outputs: got v=%b q=%h r=%h tag=%h src=%b a=%b b=%b expected all 0", rv1, q1, r1, tag1, src1, a_rdy1, b_rdy1);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (a_rdy1 !== 1'b1 || b_rdy1 !== 1'b0) begin
      fails++; $display("FAIL rstmid_a_wins: got a=%b b=%b expected 1 0", a_rdy1, b_rdy1);
    end
    tick(); a_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (lat != 16 || q1 !== 16'd5 || r1 !== 16'd1 || src1 !== 1'b0 || tag1 !== 4'd14) begin
      fails++; $display("FAIL rstmid_a_result: got lat=%0d q=%0d r=%0d src=%b tag=%0d expected 16 5 1 0 14", lat, q1, r1, src1, tag1);
    end
    tick();
    tick(); b_valid = 1'b0;
    wait_resp(lat);
    tests++;
    if (q1 !== 16'd6 || r1 !== 16'd3 || src1 !== 1'b1 || tag1 !== 4'd15) begin
      fails++; $display("FAIL rstmid_b_result: got q=%0d r=%0d src=%b tag=%0d expected 6 3 1 15", q1, r1, src1, tag1);
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; resp_ready = 1'b0; bnd_en = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    a_dvd = '0; a_dvs = '0; a_tag = '0;
    b_dvd = '0; b_dvs = '0; b_tag = '0;
    tick();
    test_reset();
    test_basic();
    test_arbitration();
    test_boundary();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
